// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite master: accepts valid/ready read/write commands,
// issues each as one SINGLE transfer and returns status on a one-cycle strobe.
module ahb_cmd_master #(
    parameter int AWIDTH  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [AWIDTH-1:0] CMD_ADDR,
    input  logic [2:0]        CMD_SIZE,
    input  logic [31:0]       CMD_WDATA,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              RSP_TIMEOUT,
    output logic              HSEL,
    output logic              HWRITE,
    output logic [AWIDTH-1:0] HADDR,
    output logic [2:0]        HSIZE,
    output logic [1:0]        HTRANS,
    output logic [31:0]       HWDATA,
    output logic [2:0]        HBURST,
    output logic              HMASTLOCK,
    output logic [3:0]        HPROT,
    input  logic              HREADY,
    input  logic [31:0]       HRDATA,
    input  logic              HRESP
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADDR   = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_REJECT = 2'd3;

    localparam logic [1:0]  TRANS_IDLE   = 2'b00;
    localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
    localparam logic [15:0] TIMEOUT_CNT  = 16'(TIMEOUT);
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    logic [1:0]        state_reg, state_next;
    logic              write_reg, write_next;
    logic [AWIDTH-1:0] addr_reg, addr_next;
    logic [2:0]        size_reg, size_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [15:0]       wait_cnt_reg, wait_cnt_next;
    logic              cmd_ready_reg, cmd_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_error_reg, rsp_error_next;
    logic              rsp_timeout_reg, rsp_timeout_next;

    logic       cmd_accept;
    logic       cmd_misaligned;
    logic [1:0] low_bit_set;

    // Address bit gi must be clear whenever the transfer is wider than 2**gi bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_align
            assign low_bit_set[gi] = CMD_ADDR[gi] && (CMD_SIZE > 3'(gi));
        end
    endgenerate

    assign cmd_misaligned = (|low_bit_set) || (CMD_SIZE > 3'd2);
    assign cmd_accept     = CMD_VALID && cmd_ready_reg;

    always_comb begin
        state_next       = state_reg;
        write_next       = write_reg;
        addr_next        = addr_reg;
        size_next        = size_reg;
        wdata_next       = wdata_reg;
        wait_cnt_next    = wait_cnt_reg;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_error_next   = rsp_error_reg;
        rsp_timeout_next = rsp_timeout_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_accept) begin
                    write_next = CMD_WRITE;
                    addr_next  = CMD_ADDR;
                    size_next  = CMD_SIZE;
                    wdata_next = CMD_WDATA;
                    state_next = cmd_misaligned ? ST_REJECT : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_next    = ST_DATA;
                    wait_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    // HRESP on the HREADY=1 cycle is the final word of a two-cycle ERROR.
                    state_next       = ST_IDLE;
                    rsp_valid_next   = 1'b1;
                    rsp_error_next   = HRESP;
                    rsp_timeout_next = 1'b0;
                    rsp_rdata_next   = (!write_reg && !HRESP) ? HRDATA : 32'd0;
                end else if (wait_cnt_reg == TIMEOUT_CNT) begin
                    state_next       = ST_IDLE;
                    rsp_valid_next   = 1'b1;
                    rsp_error_next   = 1'b1;
                    rsp_timeout_next = 1'b1;
                    rsp_rdata_next   = 32'd0;
                end else if (wait_cnt_reg != CNT_MAX) begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end
            ST_REJECT: begin
                state_next       = ST_IDLE;
                rsp_valid_next   = 1'b1;
                rsp_error_next   = 1'b1;
                rsp_timeout_next = 1'b0;
                rsp_rdata_next   = 32'd0;
            end
            default: state_next = ST_IDLE;
        endcase

        // Ready is registered so it reads 0 while reset is held.
        cmd_ready_next = (state_next == ST_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg       <= ST_IDLE;
            write_reg       <= 1'b0;
            addr_reg        <= '0;
            size_reg        <= '0;
            wdata_reg       <= '0;
            wait_cnt_reg    <= '0;
            cmd_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_error_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            write_reg       <= write_next;
            addr_reg        <= addr_next;
            size_reg        <= size_next;
            wdata_reg       <= wdata_next;
            wait_cnt_reg    <= wait_cnt_next;
            cmd_ready_reg   <= cmd_ready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_error_reg   <= rsp_error_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign CMD_READY   = cmd_ready_reg;
    assign RSP_VALID   = rsp_valid_reg;
    assign RSP_RDATA   = rsp_rdata_reg;
    assign RSP_ERROR   = rsp_error_reg;
    assign RSP_TIMEOUT = rsp_timeout_reg;

    // Address/control come straight from the command registers so they stay
    // stable across address-phase and data-phase wait states.
    assign HSEL      = (state_reg == ST_ADDR);
    assign HTRANS    = (state_reg == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = addr_reg;
    assign HWRITE    = write_reg;
    assign HSIZE     = size_reg;
    assign HWDATA    = wdata_reg;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;

endmodule

// File: doc/ahb_cmd_master.md
# ahb_cmd_master

Single-outstanding AHB-Lite master that sits directly upstream of the team's AHB slave BFM/memory model in the UART subsystem testbench. It accepts simple read/write commands on a valid/ready interface, issues them as AHB SINGLE transfers, and returns read data and status on a one-cycle response strobe. It handles slave wait states, two-cycle ERROR responses, a wait-state timeout, and rejects misaligned commands before they reach the bus.

## Interface
- AWIDTH, 10, address width; matches the slave's HADDR.
- TIMEOUT, 255, maximum data-phase wait cycles before abort (1..65535).
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  AWIDTH  byte address.
- CMD_SIZE  in  3  AHB size code 0/1/2.
- CMD_WDATA  in  32  write data.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_RDATA  out  32  captured HRDATA; 0 for writes and errors.
- RSP_ERROR  out  1  slave ERROR, misalignment, or timeout.
- RSP_TIMEOUT  out  1  abort due to timeout.
- HSEL, HWRITE  out  1 each  slave select, direction.
- HADDR  out  AWIDTH;  HSIZE  out  3;  HTRANS  out  2;  HWDATA  out  32.
- HBURST  out  3  constant 3'b000 (SINGLE);  HMASTLOCK  out  1  constant 0;  HPROT  out  4  constant 4'b0011.
- HREADY  in  1  transfer-complete from slave (its HREADYOUT).
- HRDATA  in  32;  HRESP  in  1  1 = ERROR.

## Operation
- States: IDLE, ADDR, DATA, REJECT.
- IDLE: CMD_READY=1. On accept, register WRITE/ADDR/SIZE/WDATA. Alignment check: SIZE=1 needs ADDR[0]=0; SIZE=2 needs ADDR[1:0]=0; SIZE>2 is illegal. Legal -> ADDR. Illegal -> REJECT.
- REJECT: one cycle, no bus activity. The state ends with RSP_VALID=1 and RSP_ERROR=1 in the next cycle, then returns to IDLE.
- ADDR: HTRANS=NONSEQ (2'b10), HSEL=1, HADDR/HWRITE/HSIZE from the registered command. Advance to DATA when HREADY=1; otherwise hold every address signal stable.
- DATA: HTRANS=IDLE, HSEL=0, HWDATA=registered WDATA (held for the whole data phase).
  - HREADY=1 -> capture HRDATA (reads only) and HRESP, then go to IDLE with the response registered.
  - HREADY=0 with HRESP=1 (first ERROR cycle) -> keep waiting; RSP_ERROR is taken from the cycle where HREADY=1.
  - HREADY=0 -> increment the wait counter; when the counter equals TIMEOUT -> abort to IDLE with RSP_ERROR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
- Wait counter: 16 bits, cleared on entry to DATA, saturates (no wrap).
- CMD_READY is 0 in ADDR, DATA and REJECT; only one command is outstanding at a time.
- RSP_RDATA=0 on writes, errors and timeouts; RSP_* hold their values between strobes.
- Reset: all outputs 0 except the constants HBURST=000, HMASTLOCK=0, HPROT=0011. State=IDLE, counter=0, HTRANS=IDLE.
  - Reset mid-transfer drops the transfer; no RSP_VALID is issued for it.
  - CMD_READY=1 from the first cycle after HRESET deasserts.

## Timing
- Cycle 0: accept. Cycle 1: ADDR (NONSEQ). Cycle 2: DATA, HREADY sampled. Cycle 3: RSP_VALID=1, state IDLE, CMD_READY=1.
- Minimum 3 cycles per command; a new command may be accepted in the same cycle RSP_VALID is high.
- Each data-phase wait state adds 1 cycle. Timeout strobe occurs TIMEOUT+1 cycles after DATA entry.
- Reject path: accept in cycle 0, RSP_VALID in cycle 2, HTRANS never leaves IDLE.
- HSEL is high only in ADDR-state cycles. HTRANS is never BUSY or SEQ.

## Test plan
- Write then read with a zero-wait slave: write 0xDEADBEEF to 0x010, then read 0x010 -> HTRANS=NONSEQ for exactly 1 cycle each; RSP_VALID 3 cycles after each accept; second RSP_RDATA=0xDEADBEEF, RSP_ERROR=0.
- Slave inserts 4 wait states on a read of 0x020 (memory holds 0x12345678) -> RSP_VALID 7 cycles after accept, RSP_RDATA=0x12345678; HWDATA and HADDR stable throughout.
- Two-cycle ERROR response to a write -> RSP_ERROR=1, RSP_TIMEOUT=0, RSP_RDATA=0; the next command proceeds normally.
- Misaligned commands (SIZE=2 at 0x002; SIZE=3 at 0x000) -> RSP_ERROR=1 2 cycles after accept; HSEL and HTRANS stay 0 throughout.
- TIMEOUT=8, HREADY held 0 in the data phase -> RSP_VALID with RSP_ERROR=1 and RSP_TIMEOUT=1 exactly 9 cycles after DATA entry; CMD_READY=1 the same cycle.
- HRESET asserted during the DATA phase -> next cycle all outputs at reset values, no RSP_VALID; a fresh read after release completes normally.
